// File: rtl/uart_rx_oversample.sv
`default_nettype none
// ============================================================================
// uart_rx_oversample : oversampling UART receiver, 2-of-3 mid-bit vote, 1-deep output
// Revision: 1.0
// ============================================================================
module uart_rx_oversample #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 rx_clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int C_CNT_W = $clog2(CLK_DIV);
  localparam int C_BIT_W = $clog2(DATA_BITS);
  localparam logic [C_CNT_W-1:0] C_H_M1   = C_CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [C_CNT_W-1:0] C_H      = C_CNT_W'(CLK_DIV / 2);
  localparam logic [C_CNT_W-1:0] C_H_P1   = C_CNT_W'(CLK_DIV / 2 + 1);
  localparam logic [C_CNT_W-1:0] C_LAST   = C_CNT_W'(CLK_DIV - 1);
  localparam logic [C_BIT_W-1:0] C_BIT_LAST = C_BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 sync1_q, sync2_q, prev_q;
  logic [1:0]           settle_q;
  logic                 fall_q;
  logic                 fall_d;
  logic                 s0_q, s1_q;
  logic                 vote;
  logic [C_CNT_W-1:0]   cnt_q;
  logic [C_BIT_W-1:0]   bit_q;
  logic [DATA_BITS-1:0] shift_q;

  // Edges are ignored until the whole synchronizer chain holds real line samples,
  // so the reset value of 1 cannot masquerade as a falling edge on a low line.
  assign fall_d = (settle_q == 2'd3) && prev_q && !sync2_q;
  assign vote   = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign busy   = (state_q != S_IDLE);

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      settle_q  <= 2'd0;
      fall_q    <= 1'b0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1_q   <= rx_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      fall_q    <= fall_d;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (cnt_q == C_H_M1) s0_q <= sync2_q;
      if (cnt_q == C_H) s1_q <= sync2_q;
      cnt_q <= cnt_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (fall_q) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == C_H_P1 && vote) begin
            state_q <= S_IDLE;
          end else if (cnt_q == C_LAST) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        S_DATA: begin
          if (cnt_q == C_H_P1) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
          if (cnt_q == C_LAST) begin
            cnt_q <= '0;
            if (bit_q == C_BIT_LAST) state_q <= S_STOP;
            else                     bit_q   <= bit_q + 1'b1;
          end
        end
        S_STOP: begin
          // Leave at the stop-bit decision point to catch a back-to-back start edge.
          if (cnt_q == C_H_P1) begin
            state_q <= S_IDLE;
            if (!vote) begin
              frame_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversample.sv
`default_nettype none
// Bench for uart_rx_oversample: drives serial frames bit-by-bit and checks
// received bytes, latency and status pulses against a frame-level model.
module tb_uart_rx_oversample;

  localparam int DIV     = 16;
  localparam int LATENCY = 9 * DIV + DIV / 2 + 2 + 3;

  logic       rx_clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_valid, n_ferr, n_ovr, n_busy;
  logic last_valid = 1'b0;
  logic [7:0] got[$];
  logic [7:0] sent[$];
  int starts[$];
  int rises[$];

  uart_rx_oversample #(.CLK_DIV(DIV), .DATA_BITS(8)) dut (
    .rx_clk   (rx_clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_valid = 0; n_ferr = 0; n_ovr = 0; n_busy = 0;
    got.delete(); sent.delete(); starts.delete(); rises.delete();
  endtask

  // One line cycle: log a handshake that the coming edge will perform, drive the
  // line, then observe the outputs 1 time unit after the edge.
  task automatic tick(input logic line);
    if (rx_valid && rx_ready) got.push_back(rx_data);
    rx_in = line;
    @(posedge rx_clk);
    #1;
    cyc++;
    if (rx_valid) n_valid++;
    if (rx_valid && !last_valid) rises.push_back(cyc);
    last_valid = rx_valid;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (busy) n_busy++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // Frame on the line: start 0, data LSB first, stop bit; optional one-cycle
  // inversion at glitch_pos and early return before abort_pos.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int glitch_pos, input int abort_pos);
    logic [9:0] fr;
    logic       line;
    fr = {stop, d, 1'b0};
    starts.push_back(cyc + 1);
    if (stop) sent.push_back(d);
    for (int p = 0; p < 10 * DIV; p++) begin
      if (p == abort_pos) return;
      line = fr[p / DIV];
      if (p == glitch_pos) line = ~line;
      tick(line);
    end
  endtask

  initial begin
    logic [7:0] b;
    rx_in    = 1'b1;
    rx_ready = 1'b1;
    rst      = 1'b1;
    clr();
    tick(1'b1); tick(1'b1); tick(1'b1);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_data", 32'(rx_data), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(10);

    // Single 0xA5 with consumer always ready
    clr();
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(20);
    chk("a5_rises", 32'(rises.size()), 1);
    if (rises.size() == 1) chk("a5_latency", 32'(rises[0] - starts[0]), 32'(LATENCY));
    chk("a5_valid_cycles", 32'(n_valid), 1);
    chk("a5_count", 32'(got.size()), 1);
    if (got.size() == 1) chk("a5_data", 32'(got[0]), 32'h A5);
    chk("a5_ferr", 32'(n_ferr), 0);
    chk("a5_ovr", 32'(n_ovr), 0);
    chk("a5_busy_end", 32'(busy), 0);

    // Random bytes, some back-to-back
    clr();
    for (int f = 0; f < 6; f++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, -1, -1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(20);
    chk("rnd_count", 32'(got.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < got.size(); i++)
      chk("rnd_data", 32'(got[i]), 32'(sent[i]));
    chk("rnd_rises", 32'(rises.size()), 32'(starts.size()));
    for (int i = 0; i < rises.size() && i < starts.size(); i++)
      chk("rnd_latency", 32'(rises[i] - starts[i]), 32'(LATENCY));
    chk("rnd_ovr", 32'(n_ovr), 0);
    chk("rnd_ferr", 32'(n_ferr), 0);

    // False start: 5 low cycles
    clr();
    for (int i = 0; i < 5; i++) tick(1'b0);
    idle(200);
    chk("fs_busy_seen", 32'(n_busy != 0), 1);
    chk("fs_busy_end", 32'(busy), 0);
    chk("fs_valid", 32'(n_valid), 0);
    chk("fs_ferr", 32'(n_ferr), 0);
    chk("fs_ovr", 32'(n_ovr), 0);

    // Bad stop bit, then line held low
    clr();
    send_frame(8'h3C, 1'b0, -1, -1);
    chk("fe_pulses", 32'(n_ferr), 1);
    chk("fe_valid", 32'(n_valid), 0);
    chk("fe_ovr", 32'(n_ovr), 0);
    clr();
    for (int i = 0; i < 40; i++) tick(1'b0);
    idle(100);
    chk("fe_no_rearm", 32'(n_busy), 0);
    chk("fe_no_valid", 32'(n_valid), 0);

    // Mid-bit glitch on 0x00 (data bit 3, sample at cnt = H)
    clr();
    send_frame(8'h00, 1'b1, 4 * DIV + DIV / 2 + 2, -1);
    idle(20);
    chk("gl_count", 32'(got.size()), 1);
    if (got.size() == 1) chk("gl_data", 32'(got[0]), 0);

    // Overrun with consumer stalled
    clr();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    idle(20);
    chk("ov_valid", 32'(rx_valid), 1);
    chk("ov_data", 32'(rx_data), 32'h11);
    chk("ov_pulses", 32'(n_ovr), 1);
    chk("ov_ferr", 32'(n_ferr), 0);
    rx_ready = 1'b1;
    tick(1'b1);
    chk("ov_consumed_n", 32'(got.size()), 1);
    if (got.size() == 1) chk("ov_consumed", 32'(got[0]), 32'h11);
    tick(1'b1);
    chk("ov_valid_clr", 32'(rx_valid), 0);

    // Reset during data bit 4 of 0xFF
    clr();
    send_frame(8'hFF, 1'b1, -1, 5 * DIV + DIV / 2);
    chk("mr_busy_before", 32'(busy), 1);
    rst = 1'b1;
    tick(1'b1);
    chk("mr_valid", 32'(rx_valid), 0);
    chk("mr_data", 32'(rx_data), 0);
    chk("mr_ferr", 32'(frame_err), 0);
    chk("mr_ovr", 32'(overrun), 0);
    chk("mr_busy", 32'(busy), 0);
    rst = 1'b0;
    idle(20);
    clr();
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(20);
    chk("mr_next_count", 32'(got.size()), 1);
    if (got.size() == 1) chk("mr_next_data", 32'(got[0]), 32'h5A);
    if (rises.size() == 1) chk("mr_next_latency", 32'(rises[0] - starts[0]), 32'(LATENCY));

    // Reset released while the line is low
    rst = 1'b1;
    tick(1'b0); tick(1'b0);
    rst = 1'b0;
    clr();
    for (int i = 0; i < 40; i++) tick(1'b0);
    idle(30);
    chk("rl_busy", 32'(n_busy), 0);
    chk("rl_valid", 32'(n_valid), 0);
    chk("rl_ferr", 32'(n_ferr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter CLK_DIV, default 16: rx_clk cycles per bit; SHALL be even and >= 6.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame; fixed 8 in this revision.
REQ-003 Port rx_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset; one clock and synchronous active-high reset are fixed.
REQ-005 Port rx_in  input  1  asynchronous serial line, idle high.
REQ-006 Port rx_data  output  8  received byte, LSB first on the line.
REQ-007 Port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 Port rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both 1.
REQ-009 Port frame_err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-010 Port overrun  output  1  one-cycle pulse: completed byte dropped because the output was still full.
REQ-011 Port busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use; a third register holds the previous synchronized value for edge detection.
REQ-013 States: IDLE, START, DATA, STOP; 2-state-bit encoding; any unused encoding SHALL go to IDLE.
REQ-014 IDLE -> START only on a synchronized falling edge (previous 1, current 0); a line held low SHALL NOT re-arm the receiver.
REQ-015 A bit counter cnt (0..CLK_DIV-1) SHALL clear on START entry and on every bit boundary; H = CLK_DIV/2.
REQ-016 Each bit value SHALL be the 2-of-3 majority of synchronized samples taken at cnt = H-1, H and H+1; the decision is made at cnt = H+1.
REQ-017 In START: majority 1 is a false start and SHALL return to IDLE without any output change; majority 0 SHALL lead to DATA at cnt = CLK_DIV-1.
REQ-018 In DATA: each decided bit SHALL be shifted in LSB first; after bit index 7 reaches cnt = CLK_DIV-1, go to STOP.
REQ-019 In STOP: at the decision point (cnt = H+1), go to IDLE in the same cycle; the receiver does not wait out the rest of the stop bit, so it can resync to back-to-back frames.
REQ-020 STOP majority 1 SHALL complete the frame; majority 0 SHALL pulse frame_err for one cycle, discard the byte and leave rx_data/rx_valid unchanged.
REQ-021 Latency: rx_valid SHALL rise exactly 9*CLK_DIV + H + 2 cycles after START entry; START entry is 3 cycles after the first rx_clk edge that samples rx_in low.
REQ-022 On frame completion with rx_valid = 0: load rx_data and set rx_valid on the next edge.
REQ-023 On completion with rx_valid = 1 and rx_ready = 1 in the same cycle: the old byte is consumed, the new byte is loaded, and rx_valid stays 1.
REQ-024 On completion with rx_valid = 1 and rx_ready = 0: pulse overrun for one cycle, drop the new byte, and hold the old rx_data.
REQ-025 rx_valid SHALL clear on the edge after a handshake unless REQ-023 applies; rx_data SHALL be stable while rx_valid = 1.
REQ-026 frame_err and overrun SHALL never assert for the same frame; with rx_ready tied to 1, overrun SHALL never assert.

Reset
REQ-027 When rst = 1 at a clock edge: state = IDLE; cnt, bit index and shift register = 0; rx_data = 0x00; rx_valid, frame_err, overrun, busy = 0; synchronizer flops = 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output pulse; a line still low after reset releases SHALL NOT start a frame (REQ-014).

Verification
REQ-029 Reset, CLK_DIV = 16, send 0xA5 with a valid stop bit, rx_ready = 1 -> rx_valid high for 1 cycle, 157 cycles after the first low sample, with rx_data = 0xA5.
REQ-030 Hold rx_in low for 5 cycles then high -> false start; busy returns to 0; no rx_valid, frame_err or overrun.
REQ-031 Send 0x3C with stop bit = 0 -> frame_err pulses once; rx_valid stays 0; line held low for 40 cycles then high produces no further frame.
REQ-032 rx_ready = 0, send 0x11 then 0x22 back-to-back -> rx_valid = 1 with rx_data = 0x11; overrun pulses once; raising rx_ready consumes 0x11.
REQ-033 Glitch one mid-bit sample of 0x00 to 1 (single cycle at cnt = H) -> majority yields rx_data = 0x00.
REQ-034 Assert rst during DATA bit 4 of 0xFF -> all outputs 0 next cycle; the next clean frame 0x5A is received correctly.
